// File: rtl/spad_frame_reader_pkg.sv
// Shared word-format constants, reader state encoding and word decode for the SPAD readout path.
// The producer side builds words from the same field constants.
package spad_frame_reader_pkg;
  localparam int NPIX       = 512;
  localparam int DATA_W     = 5;
  localparam int ADDR_W     = 9;
  localparam int WORD_W     = 16;
  localparam int FRAMECNT_W = 16;
  localparam int ERRCNT_W   = 8;
  localparam int SUM_W      = 14;

  localparam int WADDR_LSB  = 6;
  localparam int WADDR_W    = 10;
  localparam int WPAD_BIT   = 5;
  localparam int WDATA_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_PRESENT
  } state_e;

  typedef struct packed {
    logic [WADDR_W-1:0] a;
    logic               pad;
    logic [DATA_W-1:0]  d;
    logic               bad;
  } word_dec_t;

  // A word is format-bad when the pad bit is set or the address is past the last pixel.
  function automatic word_dec_t decode_word(input logic [WORD_W-1:0] w);
    word_dec_t r;
    r.a   = w[WADDR_LSB +: WADDR_W];
    r.pad = w[WPAD_BIT];
    r.d   = w[WDATA_LSB +: DATA_W];
    r.bad = r.pad || (32'(r.a) >= 32'(NPIX));
    return r;
  endfunction
endpackage

// File: rtl/spad_frame_reader_if.sv
// Pixel stream with valid/ready handshake from the frame reader to downstream consumers.
interface spad_frame_reader_if;
  import spad_frame_reader_pkg::*;

  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              pix_eof;

  modport master (
    output pix_valid, pix_addr, pix_data, pix_sof, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_addr, pix_data, pix_sof, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/spad_frame_reader_stats.sv
// Frame statistics: running photon sum, completed-frame sum/count and sticky sequence-error tracking.
module spad_frame_reader_stats
  import spad_frame_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_first,
  input  logic [DATA_W-1:0]     i_d,
  input  logic                  i_frame_done,
  input  logic                  i_err,
  input  logic                  i_clr_err,
  output logic [SUM_W-1:0]      o_frame_sum,
  output logic                  o_sum_valid,
  output logic [FRAMECNT_W-1:0] o_frame_cnt,
  output logic                  o_seq_err,
  output logic [ERRCNT_W-1:0]   o_err_cnt
);
  logic [SUM_W-1:0]      r_acc;
  logic [SUM_W-1:0]      r_frame_sum;
  logic                  r_sum_valid;
  logic [FRAMECNT_W-1:0] r_frame_cnt;
  logic                  r_seq_err;
  logic [ERRCNT_W-1:0]   r_err_cnt;

  // A frame start throws away whatever partial sum was being built.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_first ? SUM_W'(i_d) : r_acc + SUM_W'(i_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_sum <= '0;
      r_sum_valid <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_sum_valid <= i_frame_done;
      if (i_frame_done) begin
        r_frame_sum <= r_acc;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // A new error beats a simultaneous clear, leaving exactly one counted error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (i_err) begin
      r_seq_err <= 1'b1;
      if (i_clr_err)
        r_err_cnt <= ERRCNT_W'(1);
      else if (!(&r_err_cnt))
        r_err_cnt <= r_err_cnt + 1'b1;
    end else if (i_clr_err) begin
      r_seq_err <= 1'b0;
      r_err_cnt <= '0;
    end
  end

  assign o_frame_sum = r_frame_sum;
  assign o_sum_valid = r_sum_valid;
  assign o_frame_cnt = r_frame_cnt;
  assign o_seq_err   = r_seq_err;
  assign o_err_cnt   = r_err_cnt;
endmodule

// File: rtl/spad_frame_reader.sv
// Consumer end of the SPAD readout FIFO: pops one word at a time, checks address continuity
// and presents decoded pixels on a valid/ready stream.
module spad_frame_reader
  import spad_frame_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [WORD_W-1:0]     i_fifo_dout,
  spad_frame_reader_if.master   pix,
  output logic [SUM_W-1:0]      o_frame_sum,
  output logic                  o_sum_valid,
  output logic [FRAMECNT_W-1:0] o_frame_cnt,
  output logic                  o_seq_err,
  output logic [ERRCNT_W-1:0]   o_err_cnt,
  input  logic                  i_clr_err
);
  state_e            r_state;
  state_e            w_next;
  logic [WORD_W-1:0] r_word;
  logic [ADDR_W-1:0] r_exp_addr;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [DATA_W-1:0] r_pix_data;
  logic              r_sync;

  word_dec_t w_dec;
  logic      w_fmt_bad;
  logic      w_check;
  logic      w_first;
  logic      w_good;
  logic      w_trunc;
  logic      w_err;
  logic      w_load;
  logic      w_eof;
  logic      w_accept;

  assign w_dec     = decode_word(r_word);
  assign w_fmt_bad = w_dec.pad || w_dec.bad;
  assign w_check   = (r_state == ST_CHECK);
  assign w_first   = !w_fmt_bad && (w_dec.a == '0);
  assign w_good    = w_first || (!w_fmt_bad && r_sync && (w_dec.a == {1'b0, r_exp_addr}));
  // Address 0 arriving mid-frame means the previous frame was cut short.
  assign w_trunc   = w_first && r_sync && (r_exp_addr != '0);
  // Out-of-order words are silent while unsynchronised; format-bad words always count.
  assign w_err     = w_check && (w_fmt_bad || (r_sync && !w_good) || w_trunc);
  assign w_load    = w_check && w_good;
  assign w_eof     = (r_pix_addr == ADDR_W'(NPIX - 1));
  assign w_accept  = (r_state == ST_PRESENT) && pix.pix_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_en && !i_fifo_empty) w_next = ST_WAIT;
      ST_WAIT:    w_next = ST_CHECK;
      ST_CHECK:   w_next = w_good ? ST_PRESENT : ST_IDLE;
      ST_PRESENT: if (pix.pix_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Strobe is held off during reset so every output reads zero while rst_n is low.
  always_comb begin
    o_fifo_rd_en  = 1'b0;
    pix.pix_valid = 1'b0;
    case (r_state)
      ST_IDLE:    o_fifo_rd_en  = rst_n && i_en && !i_fifo_empty;
      ST_PRESENT: pix.pix_valid = 1'b1;
      default:    ;
    endcase
  end

  assign pix.pix_addr = r_pix_addr;
  assign pix.pix_data = r_pix_data;
  assign pix.pix_sof  = pix.pix_valid && (r_pix_addr == '0);
  assign pix.pix_eof  = pix.pix_valid && w_eof;

  // FIFO data is valid the cycle after the strobe, i.e. while in WAIT.
  always_ff @(posedge clk) begin
    if (r_state == ST_WAIT) r_word <= i_fifo_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 1'b0;
      r_exp_addr <= '0;
      r_pix_addr <= '0;
      r_pix_data <= '0;
    end else begin
      if (w_load) begin
        r_pix_addr <= w_dec.a[ADDR_W-1:0];
        r_pix_data <= w_dec.d;
        r_sync     <= 1'b1;
      end else if (w_err) begin
        r_sync     <= 1'b0;
      end
      if (w_accept) r_exp_addr <= w_eof ? '0 : r_pix_addr + 1'b1;
    end
  end

  spad_frame_reader_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_first      (w_first),
    .i_d          (w_dec.d),
    .i_frame_done (w_accept && w_eof),
    .i_err        (w_err),
    .i_clr_err    (i_clr_err),
    .o_frame_sum  (o_frame_sum),
    .o_sum_valid  (o_sum_valid),
    .o_frame_cnt  (o_frame_cnt),
    .o_seq_err    (o_seq_err),
    .o_err_cnt    (o_err_cnt)
  );
endmodule

// File: tb/tb_spad_frame_reader.sv
// Directed bench for spad_frame_reader: FIFO model, word-level behavioural model, per-cycle compare.
`timescale 1ns/1ps
module tb_spad_frame_reader;
  import spad_frame_reader_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic                  fifo_empty = 1'b1;
  logic                  fifo_rd_en;
  logic [15:0]           fifo_dout = '0;
  logic [SUM_W-1:0]      frame_sum;
  logic                  sum_valid;
  logic [FRAMECNT_W-1:0] frame_cnt;
  logic                  seq_err;
  logic [ERRCNT_W-1:0]   err_cnt;
  logic                  clr_err = 1'b0;

  spad_frame_reader_if pix_if ();

  spad_frame_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd_en (fifo_rd_en),
    .i_fifo_dout  (fifo_dout),
    .pix          (pix_if),
    .o_frame_sum  (frame_sum),
    .o_sum_valid  (sum_valid),
    .o_frame_cnt  (frame_cnt),
    .o_seq_err    (seq_err),
    .o_err_cnt    (err_cnt),
    .i_clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // FIFO model: data appears one cycle after the strobe
  logic [15:0] fq[$];
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      check("rd_en_while_empty", {63'd0, fifo_empty}, 64'd0);
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Behavioural model: the pixel stream and frame results implied by the words pushed
  typedef struct packed {
    logic [8:0] a;
    logic [4:0] d;
    logic       sof;
    logic       eof;
  } pix_t;

  pix_t        ep[$];
  logic [31:0] es[$];
  bit          m_sync = 0;
  int          m_exp = 0;
  int          m_acc = 0;
  int          m_err = 0;
  int          m_fcnt = 0;

  function automatic void model_word(input logic [15:0] w);
    int a = int'(w[15:6]);
    int d = int'(w[4:0]);
    bit fmt_bad = w[5] || (a >= NPIX);
    if (!fmt_bad && a == 0) begin
      if (m_sync && m_exp != 0) m_err++;
      m_sync = 1;
      m_acc = 0;
    end else if (fmt_bad || (m_sync && a != m_exp)) begin
      m_err++;
      m_sync = 0;
      return;
    end else if (!m_sync) begin
      return;
    end
    m_acc += d;
    ep.push_back('{a: 9'(a), d: 5'(d), sof: (a == 0), eof: (a == NPIX - 1)});
    m_exp = (a + 1) % NPIX;
    if (a == NPIX - 1) begin
      m_fcnt++;
      es.push_back({16'(m_fcnt), 16'(m_acc)});
    end
  endfunction

  function automatic logic [15:0] mk(input int a, input int d, input bit pad);
    return {10'(a), pad, 5'(d)};
  endfunction

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    model_word(w);
  endtask

  task automatic push_frame(input int first, input int last, input int skip);
    for (int i = first; i <= last; i++)
      if (i != skip) push_word(mk(i, i % 32, 1'b0));
  endtask

  // Downstream ready: optionally stalls a chosen address for a number of cycles
  int stall_at = -1;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (pix_if.pix_valid && int'(pix_if.pix_addr) == stall_at && stall_left > 0) begin
      pix_if.pix_ready = 1'b0;
      stall_left--;
    end else begin
      pix_if.pix_ready = 1'b1;
    end
  end

  // Compare process
  int         acc_pix = 0;
  int         sum_pulses = 0;
  int         stall_cycles = 0;
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [8:0] p_addr = '0;
  logic [4:0] p_data = '0;
  pix_t        e_pix;
  logic [31:0] e_sum;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        check("hold_valid", 64'(pix_if.pix_valid), 64'd1);
        check("hold_addr", 64'(pix_if.pix_addr), 64'(p_addr));
        check("hold_data", 64'(pix_if.pix_data), 64'(p_data));
      end
      if (pix_if.pix_valid && !pix_if.pix_ready) begin
        stall_cycles++;
        check("rd_during_stall", 64'(fifo_rd_en), 64'd0);
      end
      if (pix_if.pix_valid && pix_if.pix_ready) begin
        acc_pix++;
        if (ep.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pixel: got addr %0d, expected no pixel", pix_if.pix_addr);
        end else begin
          e_pix = ep.pop_front();
          check("pix_addr", 64'(pix_if.pix_addr), 64'(e_pix.a));
          check("pix_data", 64'(pix_if.pix_data), 64'(e_pix.d));
          check("pix_sof", 64'(pix_if.pix_sof), 64'(e_pix.sof));
          check("pix_eof", 64'(pix_if.pix_eof), 64'(e_pix.eof));
        end
      end
      if (sum_valid) begin
        sum_pulses++;
        if (es.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_sum_valid: got sum %0d, expected no pulse", frame_sum);
        end else begin
          e_sum = es.pop_front();
          check("frame_sum", 64'(frame_sum), 64'(e_sum[15:0]));
          check("frame_cnt", 64'(frame_cnt), 64'(e_sum[31:16]));
        end
      end
      p_valid = pix_if.pix_valid;
      p_ready = pix_if.pix_ready;
      p_addr  = pix_if.pix_addr;
      p_data  = pix_if.pix_data;
    end
  end

  task automatic drain();
    int n = 0;
    while ((fq.size() != 0 || ep.size() != 0 || es.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending pixels, expected 0", ep.size());
    end
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'((m_err > 255) ? 255 : m_err));
    check({tag, "_seq_err"}, 64'(seq_err), 64'(m_err != 0));
  endtask

  logic [63:0] outs;
  int base_pix, base_sum, base_rd, base_stall, n_wait;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    outs = {fifo_rd_en, pix_if.pix_valid, pix_if.pix_sof, pix_if.pix_eof, pix_if.pix_addr,
            pix_if.pix_data, frame_sum, sum_valid, frame_cnt, seq_err, err_cnt};
    check("reset_outputs", outs, 64'd0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Clean frame
    base_pix = acc_pix; base_sum = sum_pulses;
    push_frame(0, 511, -1);
    check("model_t1_sum", 64'(m_acc), 64'd7936);
    drain();
    check("t1_pixels", 64'(acc_pix - base_pix), 64'd512);
    check("t1_sum_pulses", 64'(sum_pulses - base_sum), 64'd1);
    check("t1_frame_sum", 64'(frame_sum), 64'd7936);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_seq_err", 64'(seq_err), 64'd0);
    check("t1_err_cnt", 64'(err_cnt), 64'd0);

    // Downstream stall at address 37
    base_pix = acc_pix; base_stall = stall_cycles;
    stall_at = 37; stall_left = 5;
    push_frame(0, 511, -1);
    drain();
    check("t2_stall_cycles", 64'(stall_cycles - base_stall), 64'd5);
    check("t2_pixels", 64'(acc_pix - base_pix), 64'd512);
    check("t2_frame_sum", 64'(frame_sum), 64'd7936);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);

    // Missing address 100, then a clean frame
    base_pix = acc_pix; base_sum = sum_pulses;
    push_frame(0, 511, 100);
    push_frame(0, 511, -1);
    drain();
    check("t3_pixels", 64'(acc_pix - base_pix), 64'd612);
    check("t3_sum_pulses", 64'(sum_pulses - base_sum), 64'd1);
    check("t3_err_cnt", 64'(err_cnt), 64'd1);
    check("t3_seq_err", 64'(seq_err), 64'd1);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd3);
    check("t3_frame_sum", 64'(frame_sum), 64'd7936);
    check_errs("t3_model");

    clr_err = 1'b1;
    @(posedge clk); #2;
    clr_err = 1'b0;
    m_err = 0;
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
    check("clr_seq_err", 64'(seq_err), 64'd0);

    // Pad bit set at address 5
    base_pix = acc_pix;
    push_frame(0, 4, -1);
    push_word(mk(5, 5, 1'b1));
    drain();
    check("t4_pixels", 64'(acc_pix - base_pix), 64'd5);
    check("t4_err_cnt", 64'(err_cnt), 64'd1);
    check("t4_seq_err", 64'(seq_err), 64'd1);

    // Clear coincident with a new error: the word is checked three edges after the FIFO sees it
    push_word(mk(7, 3, 1'b1));
    repeat (3) @(posedge clk);
    #2 clr_err = 1'b1;
    @(posedge clk);
    #2 clr_err = 1'b0;
    m_err = 1;
    repeat (4) @(posedge clk);
    #2;
    check("t4_clr_vs_err_cnt", 64'(err_cnt), 64'd1);
    check("t4_clr_vs_err_seq", 64'(seq_err), 64'd1);
    clr_err = 1'b1;
    @(posedge clk); #2;
    clr_err = 1'b0;
    m_err = 0;
    check_errs("t4_cleared");

    // Empty FIFO, then reader disabled with data waiting
    base_rd = rd_cnt;
    repeat (20) @(posedge clk);
    #2;
    check("t5_empty_reads", 64'(rd_cnt - base_rd), 64'd0);
    en = 1'b0;
    base_pix = acc_pix;
    push_frame(0, 9, -1);
    repeat (20) @(posedge clk);
    #2;
    check("t5_disabled_reads", 64'(rd_cnt - base_rd), 64'd0);
    check("t5_disabled_pixels", 64'(acc_pix - base_pix), 64'd0);
    en = 1'b1;
    drain();
    check("t5_pixels", 64'(acc_pix - base_pix), 64'd10);

    // Reset while pixel 200 is presented
    push_frame(0, 511, -1);
    n_wait = 0;
    while (!(pix_if.pix_valid && pix_if.pix_addr == 9'd200) && n_wait < 5000) begin
      @(negedge clk);
      n_wait++;
    end
    check("t6_reached_addr200", 64'(n_wait < 5000), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    outs = {fifo_rd_en, pix_if.pix_valid, pix_if.pix_sof, pix_if.pix_eof, pix_if.pix_addr,
            pix_if.pix_data, frame_sum, sum_valid, frame_cnt, seq_err, err_cnt};
    check("t6_reset_outputs", outs, 64'd0);
    ep.delete();
    es.delete();
    m_sync = 0; m_exp = 0; m_acc = 0; m_err = 0; m_fcnt = 0;
    for (int i = 0; i < fq.size(); i++) model_word(fq[i]);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    base_pix = acc_pix;
    push_frame(0, 511, -1);
    drain();
    check("t6_pixels", 64'(acc_pix - base_pix), 64'd512);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t6_frame_sum", 64'(frame_sum), 64'd7936);
    check("t6_err_cnt", 64'(err_cnt), 64'd0);
    check("t6_seq_err", 64'(seq_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spad_frame_reader.md
Name: spad_frame_reader

Overview:
- Consumer end of the SPAD readout FIFO. The pixel-readout FSM writes 16-bit words {addr[9:0], 1'b0, data[4:0]} for pixels 0..511 in order. This block pops those words and decodes them.
- Checks frame address continuity and presents a pixel stream with valid/ready handshake to downstream logic (host pipe-out / histogram).
- Maintains per-frame photon sum, frame count and error statistics.

Parameters:
- NPIX, 512, pixels per frame; legal addresses 0..NPIX-1.
- DATA_W, 5, pixel count width (word[4:0]).
- FRAMECNT_W, 16, completed-frame counter width (wraps).
- ERRCNT_W, 8, error counter width (saturates).

Ports:
- clk  in  1  system clock (same domain as the FIFO read side).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  reader enable; gates new FIFO reads only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe; standard FIFO, data valid one cycle after strobe.
- fifo_dout  in  16  FIFO read data.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_addr  out  9  pixel address.
- pix_data  out  DATA_W  pixel count.
- pix_sof  out  1  qualifies pixel 0 of a frame.
- pix_eof  out  1  qualifies pixel NPIX-1 of a frame.
- frame_sum  out  14  photon sum of the last completed frame.
- sum_valid  out  1  one-cycle pulse when frame_sum updates.
- frame_cnt  out  FRAMECNT_W  completed frames.
- seq_err  out  1  sticky error flag.
- err_cnt  out  ERRCNT_W  saturating error count.
- clr_err  in  1  synchronous clear of seq_err and err_cnt.

Behaviour:
- Reset (rst_n low, async): all outputs 0; state=IDLE; exp_addr=0; acc=0; sync=0 (no frame start seen yet).
- Decode: a = word[15:6], pad = word[5], d = word[4:0]. A word is format-bad if pad=1 or a >= NPIX.
- IDLE:
  - If en & !fifo_empty: fifo_rd_en=1 for exactly one cycle, then go to WAIT.
  - At most one read is outstanding. fifo_rd_en is never asserted while fifo_empty=1.
- WAIT: capture fifo_dout into the word register, then go to CHECK.
- CHECK (one cycle):
  - Good word: not format-bad, and either (sync=1 and a==exp_addr) or a==0.
    - If a==0: acc restarts at d; sync=1.
    - Otherwise: acc += d.
    - Load the pix_* registers, then go to PRESENT.
  - a==0 while sync=1 and exp_addr!=0: this is an error (truncated frame). Discard the partial acc, set seq_err, err_cnt+1, then accept the word as a new frame start.
  - Any other bad word: set seq_err, err_cnt+1 (saturating at all-ones), sync=0, drop the word, return to IDLE.
  - When sync=0, words with a!=0 are dropped silently with no error. This is resync mode.
- PRESENT:
  - pix_valid=1; pix_sof=(pix_addr==0); pix_eof=(pix_addr==NPIX-1).
  - All pix_* outputs hold stable until pix_valid & pix_ready.
  - On accept: exp_addr = pix_addr+1. If eof: frame_sum=acc, sum_valid pulse, frame_cnt+1 (wraps), exp_addr=0. Then go to IDLE.
- Latency: FIFO not empty to pix_valid = 4 cycles (IDLE, WAIT, CHECK, PRESENT). Maximum throughput is one pixel per 4 cycles, which exceeds the producer rate.
- en low: no new fifo_rd_en. An in-flight read or presented pixel completes. Frame state (exp_addr, acc, sync) is preserved.
- clr_err coincident with a new error: the error wins, giving seq_err=1 and err_cnt=1.
- frame_sum width: 512×31 = 15872 < 2^14, so 14 bits is sufficient.

Decomposition:
- Package spad_pkg: NPIX, DATA_W, word field offsets, state enum (IDLE, WAIT, CHECK, PRESENT), and a decode function returning {a, pad, d, bad}. The producer side shares the same field constants.
- One sub-module: spad_frame_stats. It holds acc, frame_sum/sum_valid, frame_cnt, seq_err/err_cnt with saturation, and clr_err priority.

Test Plan:
- 512 words, addr 0..511 with data=addr%32, pix_ready=1 → 512 pixels; sof only on addr 0, eof only on 511; frame_sum=7936; one sum_valid pulse; frame_cnt=1; seq_err=0.
- Same frame with pix_ready low for 5 cycles at addr 37 → pix_addr/pix_data stable while stalled; no fifo_rd_en during the stall; no word loss; frame_sum=7936.
- Frame missing addr 100, then a full clean frame:
  - 1 error at addr 101; words 101..511 dropped silently.
  - Truncation is not re-flagged at the next frame's addr 0, because sync=0.
  - err_cnt=1; frame_cnt=1 (clean frame only); frame_sum=7936.
- Word with pad bit set at addr 5 → dropped; seq_err=1; err_cnt=1; clr_err pulse → both 0. clr_err concurrent with a new error → err_cnt=1.
- FIFO empty with en=1 for 20 cycles → fifo_rd_en stays 0. en=0 with FIFO non-empty → no reads.
- rst_n asserted mid-frame at addr 200 → all outputs 0 immediately. Subsequent words 201..511 dropped without error; the next frame starting at addr 0 completes with frame_cnt=1.
